sound_playback: RTL and testbench

- Downstream consumer of the 1024x8 sound sample buffer.
- Reads one 8-bit sample per sample period through the buffer's registered read port (1-cycle read latency) and advances a circular read pointer against the writer's write pointer.
- Drives a PWM audio output, and flags buffer-full, low-water and underrun conditions to the bus-side writer and the interrupt logic.

---
 rtl/sound_playback.sv | 181 ++++++++++++++++++
 tb/tb_sound_playback.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_playback.sv
// Sample-buffer consumer: fetches one sample per sample period through the buffer's
// registered read port, tracks fill level against the writer pointer and drives PWM audio.
module sound_playback #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int LOW_WATER  = 512
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  flush,
  input  logic [DIV_WIDTH-1:0]  sampleDivisor,
  input  logic [ADDR_WIDTH-1:0] writeAddress,
  output logic [ADDR_WIDTH-1:0] readAddress,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  underrunClear,
  output logic [ADDR_WIDTH-1:0] fillLevel,
  output logic                  bufferFull,
  output logic                  lowWater,
  output logic                  underrun,
  output logic [DATA_WIDTH-1:0] sample,
  output logic                  pwmOut
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  localparam logic [DIV_WIDTH-1:0] MIN_DIV = DIV_WIDTH'(3);

  state_t                  state_r;
  state_t                  state_next_s;
  logic [DIV_WIDTH-1:0]    divider_r;
  logic [DIV_WIDTH-1:0]    div_eff_s;
  logic                    tick_s;
  logic [ADDR_WIDTH-1:0]   read_addr_r;
  logic [ADDR_WIDTH-1:0]   fill_s;
  logic                    empty_s;
  logic [DATA_WIDTH-1:0]   sample_r;
  logic [DATA_WIDTH-1:0]   pwm_count_r;
  logic                    pwm_r;
  logic                    underrun_r;
  logic                    capture_s;
  logic                    underrun_set_s;

  // Pointer-derived status; one slot is always left empty so full and empty differ.
  always_comb begin
    fill_s     = writeAddress - read_addr_r;
    empty_s    = (fill_s == {ADDR_WIDTH{1'b0}});
    bufferFull = (fill_s == {ADDR_WIDTH{1'b1}});
    lowWater   = ({1'b0, fill_s} < (ADDR_WIDTH + 1)'(LOW_WATER));
  end

  // Clamp the divisor so a read always completes before the next tick.
  always_comb begin
    if (sampleDivisor < MIN_DIV) begin
      div_eff_s = MIN_DIV;
    end else begin
      div_eff_s = sampleDivisor;
    end
    if (enable && (divider_r >= div_eff_s)) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
  end

  // Sample-period divider.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      divider_r <= DIV_WIDTH'(0);
    end else if (!enable || tick_s) begin
      divider_r <= DIV_WIDTH'(0);
    end else begin
      divider_r <= divider_r + DIV_WIDTH'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; flush and disable abort any read in flight.
  always_comb begin
    state_next_s = state_r;
    if (!enable || flush) begin
      state_next_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (tick_s && !empty_s) begin
            state_next_s = READ;
          end else begin
            state_next_s = IDLE;
          end
        end
        READ:    state_next_s = CAPTURE;
        CAPTURE: state_next_s = IDLE;
        default: state_next_s = IDLE;
      endcase
    end
  end

  // FSM outputs: the empty/full decision is only taken in IDLE at the tick.
  always_comb begin
    capture_s      = 1'b0;
    underrun_set_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (tick_s && empty_s) begin
          underrun_set_s = 1'b1;
        end else begin
          underrun_set_s = 1'b0;
        end
      end
      CAPTURE: begin
        if (enable && !flush) begin
          capture_s = 1'b1;
        end else begin
          capture_s = 1'b0;
        end
      end
      default: begin
        capture_s      = 1'b0;
        underrun_set_s = 1'b0;
      end
    endcase
  end

  // Read pointer, captured sample and sticky underrun (set beats clear).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_addr_r <= ADDR_WIDTH'(0);
      sample_r    <= DATA_WIDTH'(8'h80);
      underrun_r  <= 1'b0;
    end else begin
      if (flush) begin
        read_addr_r <= writeAddress;
      end else if (capture_s) begin
        read_addr_r <= read_addr_r + ADDR_WIDTH'(1);
      end
      if (capture_s) begin
        sample_r <= dataIn;
      end
      if (underrun_set_s) begin
        underrun_r <= 1'b1;
      end else if (underrunClear) begin
        underrun_r <= 1'b0;
      end
    end
  end

  // PWM counter and comparator output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_count_r <= DATA_WIDTH'(0);
      pwm_r       <= 1'b0;
    end else if (!enable) begin
      pwm_count_r <= DATA_WIDTH'(0);
      pwm_r       <= 1'b0;
    end else begin
      pwm_count_r <= pwm_count_r + DATA_WIDTH'(1);
      pwm_r       <= (pwm_count_r < sample_r);
    end
  end

  assign readAddress = read_addr_r;
  assign fillLevel   = fill_s;
  assign underrun    = underrun_r;
  assign sample      = sample_r;
  assign pwmOut      = pwm_r;

endmodule

// File: tb/tb_sound_playback.sv
// Bench for sound_playback: buffer memory model, cycle-level behavioural reference
// compared on every cycle, directed scenarios with literal expectations, then random traffic.
module tb_sound_playback;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        flush;
  logic [15:0] sampleDivisor;
  logic [9:0]  writeAddress;
  logic [9:0]  readAddress;
  logic [7:0]  dataIn;
  logic        underrunClear;
  logic [9:0]  fillLevel;
  logic        bufferFull;
  logic        lowWater;
  logic        underrun;
  logic [7:0]  sample;
  logic        pwmOut;

  logic [7:0]  mem [0:1023];
  int checks = 0;
  int failures = 0;

  // reference model state
  int m_rd, m_sample, m_under, m_pwm, run, now;
  bit pend;
  int pend_time, pend_addr;

  sound_playback dut (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush),
    .sampleDivisor(sampleDivisor), .writeAddress(writeAddress),
    .readAddress(readAddress), .dataIn(dataIn), .underrunClear(underrunClear),
    .fillLevel(fillLevel), .bufferFull(bufferFull), .lowWater(lowWater),
    .underrun(underrun), .sample(sample), .pwmOut(pwmOut)
  );

  always #5 clk = ~clk;

  // buffer's registered read port
  always @(posedge clk) dataIn <= mem[readAddress];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0d expected=%0d", nm, $time, act, exp);
    end
  endtask

  // One clock edge of the reference: tick every D+1 enabled cycles, sample lands 2 edges later.
  task automatic model_step();
    int d, fill;
    bit tick, set, cap, pend_old;
    set = 1'b0;
    now++;
    if (reset) begin
      m_rd = 0; m_sample = 8'h80; m_under = 0; m_pwm = 0; run = 0; pend = 1'b0;
      return;
    end
    if (!enable) begin
      run = 0; pend = 1'b0; m_pwm = 0;
      if (flush) m_rd = writeAddress;
    end else begin
      d = (sampleDivisor < 16'd3) ? 3 : int'(sampleDivisor);
      tick = ((run % (d + 1)) == d);
      fill = (int'(writeAddress) - m_rd) & 1023;
      m_pwm = ((run % 256) < m_sample) ? 1 : 0;
      pend_old = pend;
      cap = pend && (now == pend_time);
      set = tick && !pend_old && (fill == 0);
      if (tick && !pend_old && fill != 0 && !flush) begin
        pend = 1'b1; pend_time = now + 2; pend_addr = m_rd;
      end
      if (flush) begin
        m_rd = writeAddress; pend = 1'b0;
      end else if (cap) begin
        m_sample = mem[pend_addr]; m_rd = (m_rd + 1) % 1024; pend = 1'b0;
      end
      run++;
    end
    if (set) m_under = 1;
    else if (underrunClear) m_under = 0;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // compare process, away from the active edge
  initial forever begin
    int fill;
    @(negedge clk);
    if (!reset) begin
      fill = (int'(writeAddress) - m_rd) & 1023;
      chk("readAddress", readAddress, m_rd);
      chk("sample", sample, m_sample);
      chk("underrun", underrun, m_under);
      chk("pwmOut", pwmOut, m_pwm);
      chk("fillLevel", fillLevel, fill);
      chk("bufferFull", bufferFull, (fill == 1023) ? 1 : 0);
      chk("lowWater", lowWater, (fill < 512) ? 1 : 0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wr_sample(input logic [7:0] v);
    mem[writeAddress] = v;
    writeAddress = writeAddress + 10'd1;
  endtask

  initial begin
    int cnt, start, rate;
    logic [7:0] last;
    reset = 1'b1; enable = 1'b0; flush = 1'b0; underrunClear = 1'b0;
    sampleDivisor = 16'd9; writeAddress = 10'd0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'd0;
    cyc(3);
    reset = 1'b0;
    #1;
    chk("rst_sample", sample, 8'h80);
    chk("rst_readAddress", readAddress, 0);
    chk("rst_fillLevel", fillLevel, 0);
    chk("rst_lowWater", lowWater, 1);
    chk("rst_bufferFull", bufferFull, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_pwmOut", pwmOut, 0);

    // empty buffer: first tick after 10 cycles raises underrun
    enable = 1'b1;
    cyc(9);
    chk("t1_underrun_early", underrun, 0);
    cyc(1);
    chk("t1_underrun_set", underrun, 1);
    chk("t1_sample_held", sample, 8'h80);
    chk("t1_readAddress", readAddress, 0);
    underrunClear = 1'b1; cyc(1); underrunClear = 1'b0;
    chk("t1_underrun_clr", underrun, 0);

    // four preloaded samples, 10 cycles apart
    enable = 1'b0; cyc(1);
    wr_sample(8'h10); wr_sample(8'h20); wr_sample(8'h30); wr_sample(8'h40);
    enable = 1'b1;
    cyc(11);
    chk("t2_before_first", sample, 8'h80);
    cyc(1);
    chk("t2_s0", sample, 8'h10);
    cyc(10); chk("t2_s1", sample, 8'h20);
    cyc(10); chk("t2_s2", sample, 8'h30);
    cyc(10); chk("t2_s3", sample, 8'h40);
    chk("t2_readAddress", readAddress, 4);
    chk("t2_fill", fillLevel, 0);
    cyc(7); chk("t2_no_underrun_yet", underrun, 0);
    cyc(1); chk("t2_underrun_5th", underrun, 1);

    // wraparound across 1023 -> 0 and the full condition
    enable = 1'b0; sampleDivisor = 16'd3;
    underrunClear = 1'b1; writeAddress = 10'd1020; flush = 1'b1;
    cyc(1);
    underrunClear = 1'b0; flush = 1'b0;
    for (int i = 0; i < 7; i++) wr_sample(8'hA0 + 8'(i));
    #1;
    chk("t3_fill7", fillLevel, 7);
    chk("t3_low7", lowWater, 1);
    writeAddress = 10'd1019;
    #1;
    chk("t3_fill1023", fillLevel, 1023);
    chk("t3_full", bufferFull, 1);
    cyc(1);
    writeAddress = 10'd3;
    enable = 1'b1;
    cyc(31);
    chk("t3_rd_wrapped", readAddress, 3);
    chk("t3_last_sample", sample, 8'hA6);

    // flush during READ, then disable during CAPTURE
    enable = 1'b0; sampleDivisor = 16'd9; cyc(1);
    wr_sample(8'h11); wr_sample(8'h22);
    enable = 1'b1;
    cyc(10);
    writeAddress = 10'd200; flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    chk("t4_flush_rd", readAddress, 200);
    cyc(3);
    chk("t4_flush_sample", sample, 8'hA6);
    wr_sample(8'h5A);
    cyc(7);
    enable = 1'b0;
    cyc(1);
    chk("t4_dis_rd", readAddress, 200);
    chk("t4_dis_pwm", pwmOut, 0);
    chk("t4_dis_sample", sample, 8'hA6);

    // PWM duty for 0x40 and 0x00
    mem[200] = 8'h40;
    enable = 1'b1;
    cyc(14);
    chk("t5_sample40", sample, 8'h40);
    cnt = 0;
    repeat (256) begin cyc(1); cnt += int'(pwmOut); end
    chk("t5_duty64", cnt, 64);
    enable = 1'b0; cyc(1);
    wr_sample(8'h00);
    enable = 1'b1;
    cyc(14);
    chk("t5_sample00", sample, 0);
    cnt = 0;
    repeat (256) begin cyc(1); cnt += int'(pwmOut); end
    chk("t5_duty0", cnt, 0);

    // clamped divisor: 16 back-to-back reads at a 4-cycle period
    enable = 1'b0; sampleDivisor = 16'd0; underrunClear = 1'b1; cyc(1);
    underrunClear = 1'b0;
    start = readAddress;
    last = 8'd0;
    for (int i = 0; i < 16; i++) begin last = 8'($urandom); wr_sample(last); end
    enable = 1'b1;
    cyc(66);
    chk("t6_rd16", readAddress, (start + 16) % 1024);
    chk("t6_last", sample, last);
    chk("t6_underrun", underrun, 0);

    // random traffic against the reference
    rate = 3;
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) rate = $urandom_range(1, 6);
      flush = ($urandom_range(0, 63) == 0);
      underrunClear = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 99) == 0) begin
        if (enable) begin
          enable = 1'b0;
          sampleDivisor = 16'($urandom_range(0, 12));
        end else begin
          enable = 1'b1;
        end
      end
      if ($urandom_range(0, 7) < rate && (((int'(writeAddress) - m_rd) & 1023) < 1023))
        wr_sample(8'($urandom));
      cyc(1);
    end
    flush = 1'b0; underrunClear = 1'b0;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
